fp_multiplier: RTL

Iterative floating-point multiplier that implements the responder side of the same start/valid_out/ready_in operand handshake used by `fp_adder`. A controller drops it in beside the adder with identical wiring. It accepts two operands on a `start` pulse and multiplies significands with a radix-2 shift-add loop. It normalizes, rounds, and presents `result`/`flags` under a valid/ready hold.

---
 rtl/fp_multiplier.sv | 307 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_multiplier.sv
// fp_multiplier: iterative binary32/binary16 multiplier with a start/valid/ready
// handshake. Significands are multiplied by a radix-2 shift-add loop, then the
// product is normalized, rounded (RNE or RTZ) and held until the consumer takes it.
module fp_multiplier (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        mode_fp,
    input  logic        round_mode,
    input  logic        start,
    input  logic        ready_in,
    output logic [31:0] result,
    output logic        valid_out,
    output logic [4:0]  flags
);

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        MUL,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t state, state_next;

    // Latched request
    logic [31:0] a_q, b_q;
    logic        mode_q, rm_q;

    // Working datapath registers
    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [47:0]        mcand_q;
    logic [23:0]        mplier_q;
    logic [47:0]        acc_q;
    logic [4:0]         cnt_q;
    logic [22:0]        mant_q;
    logic               guard_q;
    logic               sticky_q;
    logic               special_q;
    logic [31:0]        spec_result_q;
    logic [4:0]         spec_flags_q;

    // Unpack decode signals
    logic               sign_a, sign_b;
    logic [7:0]         exp_a, exp_b, exp_max;
    logic [22:0]        frac_a, frac_b;
    logic               qbit_a, qbit_b;
    logic               zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b;
    logic [23:0]        sig_a, sig_b;
    logic signed [9:0]  bias;
    logic signed [9:0]  exp_sum;
    logic               prod_sign;
    logic               is_special;
    logic [31:0]        spec_result;
    logic [4:0]         spec_flags;
    logic [31:0]        qnan_val, inf_val, zero_val;

    // Normalize signals
    logic [22:0]        n_mant;
    logic               n_guard, n_sticky, n_shift;

    // Round signals
    logic               rnd_inc, rnd_carry, r_inexact;
    logic [23:0]        mant_sum;
    logic signed [9:0]  exp_fin, exp_lim;
    logic [31:0]        r_result;
    logic [4:0]         r_flags;

    logic [4:0]         n_last;

    // Last loop index: 24 iterations for single, 11 for half
    assign n_last = mode_q ? 5'd23 : 5'd10;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; specials pass through ROUND so their latency is fixed at two cycles
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = UNPACK;
            UNPACK:  state_next = is_special ? ROUND : MUL;
            MUL:     if (cnt_q == n_last) state_next = NORM;
            NORM:    state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (ready_in) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Field split, special-case classification and exponent sum of the latched operands
    always_comb begin
        sign_a      = 1'b0;
        sign_b      = 1'b0;
        exp_a       = 8'd0;
        exp_b       = 8'd0;
        frac_a      = 23'd0;
        frac_b      = 23'd0;
        exp_max     = 8'h1F;
        qbit_a      = 1'b0;
        qbit_b      = 1'b0;
        sig_a       = 24'd0;
        sig_b       = 24'd0;
        bias        = 10'sd15;
        qnan_val    = 32'h0000_7E00;
        if (mode_q) begin
            sign_a   = a_q[31];
            sign_b   = b_q[31];
            exp_a    = a_q[30:23];
            exp_b    = b_q[30:23];
            frac_a   = a_q[22:0];
            frac_b   = b_q[22:0];
            exp_max  = 8'hFF;
            qbit_a   = a_q[22];
            qbit_b   = b_q[22];
            sig_a    = {1'b1, a_q[22:0]};
            sig_b    = {1'b1, b_q[22:0]};
            bias     = 10'sd127;
            qnan_val = 32'h7FC0_0000;
        end else begin
            sign_a   = a_q[15];
            sign_b   = b_q[15];
            exp_a    = {3'b000, a_q[14:10]};
            exp_b    = {3'b000, b_q[14:10]};
            frac_a   = {13'd0, a_q[9:0]};
            frac_b   = {13'd0, b_q[9:0]};
            qbit_a   = a_q[9];
            qbit_b   = b_q[9];
            sig_a    = {13'd0, 1'b1, a_q[9:0]};
            sig_b    = {13'd0, 1'b1, b_q[9:0]};
        end

        prod_sign = sign_a ^ sign_b;
        zero_a    = (exp_a == 8'd0);
        zero_b    = (exp_b == 8'd0);
        inf_a     = (exp_a == exp_max) && (frac_a == 23'd0);
        inf_b     = (exp_b == exp_max) && (frac_b == 23'd0);
        nan_a     = (exp_a == exp_max) && (frac_a != 23'd0);
        nan_b     = (exp_b == exp_max) && (frac_b != 23'd0);
        snan_a    = nan_a && !qbit_a;
        snan_b    = nan_b && !qbit_b;

        exp_sum   = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - bias;

        if (mode_q) begin
            inf_val  = {prod_sign, 8'hFF, 23'd0};
            zero_val = {prod_sign, 31'd0};
        end else begin
            inf_val  = {16'd0, prod_sign, 5'h1F, 10'd0};
            zero_val = {16'd0, prod_sign, 15'd0};
        end

        is_special = nan_a | nan_b | inf_a | inf_b | zero_a | zero_b;
        if (nan_a | nan_b | (inf_a & zero_b) | (zero_a & inf_b)) begin
            spec_result = qnan_val;
            spec_flags  = {(snan_a | snan_b | (inf_a & zero_b) | (zero_a & inf_b)), 4'b0000};
        end else if (inf_a | inf_b) begin
            spec_result = inf_val;
            spec_flags  = 5'b00000;
        end else begin
            spec_result = zero_val;
            spec_flags  = 5'b00000;
        end
    end

    // Pick the mantissa window, guard and sticky from the raw product
    always_comb begin
        n_mant   = 23'd0;
        n_guard  = 1'b0;
        n_sticky = 1'b0;
        n_shift  = 1'b0;
        if (mode_q) begin
            if (acc_q[47]) begin
                n_mant   = acc_q[46:24];
                n_guard  = acc_q[23];
                n_sticky = |acc_q[22:0];
                n_shift  = 1'b1;
            end else begin
                n_mant   = acc_q[45:23];
                n_guard  = acc_q[22];
                n_sticky = |acc_q[21:0];
            end
        end else begin
            if (acc_q[21]) begin
                n_mant   = {13'd0, acc_q[20:11]};
                n_guard  = acc_q[10];
                n_sticky = |acc_q[9:0];
                n_shift  = 1'b1;
            end else begin
                n_mant   = {13'd0, acc_q[19:10]};
                n_guard  = acc_q[9];
                n_sticky = |acc_q[8:0];
            end
        end
    end

    // Rounding increment, carry renormalization and overflow/underflow substitution
    always_comb begin
        r_inexact = guard_q | sticky_q;
        rnd_inc   = ~rm_q & guard_q & (sticky_q | mant_q[0]);
        mant_sum  = {1'b0, mant_q} + {23'd0, rnd_inc};
        rnd_carry = mode_q ? mant_sum[23] : mant_sum[10];
        exp_fin   = exp_q + (rnd_carry ? 10'sd1 : 10'sd0);
        exp_lim   = mode_q ? 10'sd255 : 10'sd31;
        r_flags   = {4'b0000, r_inexact};
        if (mode_q) begin
            r_result = {sign_q, exp_fin[7:0], mant_sum[22:0]};
        end else begin
            r_result = {16'd0, sign_q, exp_fin[4:0], mant_sum[9:0]};
        end

        if (exp_fin >= exp_lim) begin
            r_flags = 5'b00101;
            if (mode_q) begin
                r_result = rm_q ? {sign_q, 8'hFE, 23'h7FFFFF} : {sign_q, 8'hFF, 23'd0};
            end else begin
                r_result = rm_q ? {16'd0, sign_q, 5'h1E, 10'h3FF} : {16'd0, sign_q, 5'h1F, 10'd0};
            end
        end else if (exp_fin <= 10'sd0) begin
            r_flags  = 5'b00011;
            r_result = mode_q ? {sign_q, 31'd0} : {16'd0, sign_q, 15'd0};
        end
    end

    // Datapath and registered outputs, advanced according to the current state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q           <= 32'd0;
            b_q           <= 32'd0;
            mode_q        <= 1'b0;
            rm_q          <= 1'b0;
            sign_q        <= 1'b0;
            exp_q         <= 10'sd0;
            mcand_q       <= 48'd0;
            mplier_q      <= 24'd0;
            acc_q         <= 48'd0;
            cnt_q         <= 5'd0;
            mant_q        <= 23'd0;
            guard_q       <= 1'b0;
            sticky_q      <= 1'b0;
            special_q     <= 1'b0;
            spec_result_q <= 32'd0;
            spec_flags_q  <= 5'd0;
            result        <= 32'd0;
            flags         <= 5'd0;
            valid_out     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= op_a;
                        b_q    <= op_b;
                        mode_q <= mode_fp;
                        rm_q   <= round_mode;
                    end
                end
                UNPACK: begin
                    sign_q        <= prod_sign;
                    exp_q         <= exp_sum;
                    mcand_q       <= {24'd0, sig_a};
                    mplier_q      <= sig_b;
                    acc_q         <= 48'd0;
                    cnt_q         <= 5'd0;
                    special_q     <= is_special;
                    spec_result_q <= spec_result;
                    spec_flags_q  <= spec_flags;
                end
                MUL: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= {mcand_q[46:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[23:1]};
                    cnt_q    <= cnt_q + 5'd1;
                end
                NORM: begin
                    mant_q   <= n_mant;
                    guard_q  <= n_guard;
                    sticky_q <= n_sticky;
                    exp_q    <= exp_q + (n_shift ? 10'sd1 : 10'sd0);
                end
                ROUND: begin
                    result    <= special_q ? spec_result_q : r_result;
                    flags     <= special_q ? spec_flags_q : r_flags;
                    valid_out <= 1'b1;
                end
                DONE: begin
                    if (ready_in) begin
                        valid_out <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
